// File: rtl/switch_led_debounce.sv
// Per-channel switch synchroniser, debouncer and LED driver with follow/toggle modes.
// Optional blink gating on masked channels is built when SWITCH_LED_BLINK_EN is defined.
module switch_led_debounce #(
  parameter int                NUM_CH          = 4,
  parameter int                DEBOUNCE_CYCLES = 120000,
  parameter int                BLINK_DIV       = 3000000,
  parameter logic [NUM_CH-1:0] BLINK_MASK      = {NUM_CH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] switch,
  input  logic              mode,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] sw_state,
  output logic [NUM_CH-1:0] sw_rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;
  logic [NUM_CH-1:0] state_q;
  logic [NUM_CH-1:0] state_d;
  logic [NUM_CH-1:0] rise_q;
  logic [NUM_CH-1:0] rise_d;
  logic [NUM_CH-1:0] led_q;
  logic [NUM_CH-1:0] led_d;
  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [CW-1:0]     cnt_d [NUM_CH];

  // Two-flop synchroniser; only sync2_q feeds the debouncer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= switch;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive mismatches, accept on the last one, any match restarts.
  always_comb begin
    state_d = state_q;
    rise_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] == state_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        state_d[i] = sync2_q[i];
        rise_d[i]  = sync2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // LED follows the debounced level, or flips on each registered press in toggle mode.
  always_comb begin
    led_d = led_q;
    if (mode) begin
      led_d = led_q ^ rise_q;
    end else begin
      led_d = state_q;
    end
  end

  // Debounce counters, debounced level, press pulse and LED register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '{default: '0};
      state_q <= '0;
      rise_q  <= '0;
      led_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rise_q  <= rise_d;
      led_q   <= led_d;
    end
  end

  assign sw_state = state_q;
  assign sw_rise  = rise_q;

`ifdef SWITCH_LED_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt_q;
  logic [BW-1:0] blink_cnt_d;
  logic          phase_q;
  logic          phase_d;

  // Free-running blink divider; phase flips on every wrap.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      phase_d     = phase_q;
    end
  end

  // Blink divider state; phase starts high out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_led
    if (BLINK_MASK[g]) begin : g_masked
      logic out_q;
      // Masked channels are gated by phase through one extra register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_q <= 1'b0;
        end else begin
          out_q <= led_q[g] & phase_q;
        end
      end
      assign led[g] = out_q;
    end else begin : g_plain
      assign led[g] = led_q[g];
    end
  end
`else
  logic unused_blink_s;
  assign unused_blink_s = (^BLINK_MASK) ^ (BLINK_DIV != 0);
  assign led = led_q;
`endif

endmodule
